// File: rtl/spi_byte_master_pkg.sv
// Shared definitions for the byte-oriented SPI master: FSM states and default divider.
package spi_byte_master_pkg;

   localparam int unsigned SPI_CLK_DIV_DEFAULT = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_HOLD = 2'd2
   } spi_state_t;

endpackage

// File: rtl/spi_byte_master_clk_gen.sv
// Divider for the SPI master: counts clk cycles within one sclk period while
// running and flags the rising-edge and falling-edge cycles.
module spi_byte_master_clk_gen #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic rise_stb,
   output logic fall_stb
);

   localparam int unsigned CW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] RISE_AT = CW'(CLK_DIV / 2 - 1);
   localparam logic [CW-1:0] FALL_AT = CW'(CLK_DIV - 1);

   logic [CW-1:0] div_cnt;

   // Held at zero outside a transfer so every byte starts on a fresh period.
   always_ff @(posedge clk) begin
      if (rst || !run || div_cnt == FALL_AT) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   always_comb begin
      rise_stb = run && (div_cnt == RISE_AT);
      fall_stb = run && (div_cnt == FALL_AT);
   end

endmodule

// File: rtl/spi_byte_master.sv
// SPI master, mode 0, MSB first: one byte per req pulse, chip select held low
// across bytes until a finish pulse releases it.
module spi_byte_master
   import spi_byte_master_pkg::*;
#(
   parameter int unsigned CLK_DIV = SPI_CLK_DIV_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req,
   input  logic [7:0] din,
   input  logic       finish,
   output logic       done,
   output logic [7:0] dout,
   output logic       spi_sclk,
   input  logic       spi_miso,
   output logic       spi_mosi,
   output logic       spi_cs
);

   spi_state_t state, state_nx;
   logic [7:0] tx_sr, tx_sr_nx;
   logic [7:0] rx_sr, rx_sr_nx;
   logic [7:0] dout_nx;
   logic [2:0] bit_cnt, bit_cnt_nx;
   logic       finish_pend, finish_pend_nx;
   logic       sclk_nx, mosi_nx, cs_nx, done_nx;
   logic       xfer_active;
   logic       rise_stb;
   logic       sclk_done;

   assign xfer_active = (state == ST_XFER);

   spi_byte_master_clk_gen #(
      .CLK_DIV(CLK_DIV)
   ) u_clk_gen (
      .clk      (clk),
      .rst      (rst),
      .run      (xfer_active),
      .rise_stb (rise_stb),
      .fall_stb (sclk_done)
   );

   always_comb begin
      state_nx       = state;
      tx_sr_nx       = tx_sr;
      rx_sr_nx       = rx_sr;
      dout_nx        = dout;
      bit_cnt_nx     = bit_cnt;
      finish_pend_nx = finish_pend;
      sclk_nx        = spi_sclk;
      mosi_nx        = spi_mosi;
      cs_nx          = spi_cs;
      done_nx        = 1'b0;

      unique case (state)
         ST_IDLE: begin
            finish_pend_nx = 1'b0;
            if (req) begin
               tx_sr_nx   = din;
               mosi_nx    = din[7];
               cs_nx      = 1'b0;
               bit_cnt_nx = '0;
               state_nx   = ST_XFER;
            end
         end

         ST_XFER: begin
            // A finish arriving mid-byte is remembered and acted on from HOLD.
            if (finish) begin
               finish_pend_nx = 1'b1;
            end
            if (rise_stb) begin
               sclk_nx  = 1'b1;
               rx_sr_nx = {rx_sr[6:0], spi_miso};
            end
            if (sclk_done) begin
               sclk_nx = 1'b0;
               if (bit_cnt == 3'd7) begin
                  dout_nx  = rx_sr;
                  done_nx  = 1'b1;
                  state_nx = ST_HOLD;
               end else begin
                  tx_sr_nx   = {tx_sr[6:0], 1'b0};
                  mosi_nx    = tx_sr[6];
                  bit_cnt_nx = bit_cnt + 3'd1;
               end
            end
         end

         ST_HOLD: begin
            if (finish || finish_pend) begin
               cs_nx          = 1'b1;
               mosi_nx        = 1'b0;
               finish_pend_nx = 1'b0;
               state_nx       = ST_IDLE;
            end else if (req) begin
               tx_sr_nx   = din;
               mosi_nx    = din[7];
               bit_cnt_nx = '0;
               state_nx   = ST_XFER;
            end
         end

         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         tx_sr       <= '0;
         rx_sr       <= '0;
         dout        <= '0;
         bit_cnt     <= '0;
         finish_pend <= 1'b0;
         spi_sclk    <= 1'b0;
         spi_mosi    <= 1'b0;
         spi_cs      <= 1'b1;
         done        <= 1'b0;
      end else begin
         state       <= state_nx;
         tx_sr       <= tx_sr_nx;
         rx_sr       <= rx_sr_nx;
         dout        <= dout_nx;
         bit_cnt     <= bit_cnt_nx;
         finish_pend <= finish_pend_nx;
         spi_sclk    <= sclk_nx;
         spi_mosi    <= mosi_nx;
         spi_cs      <= cs_nx;
         done        <= done_nx;
      end
   end

endmodule

// File: tb/tb_spi_byte_master.sv
// Randomized scoreboard bench for spi_byte_master with a behavioural SPI slave.
module tb_spi_byte_master;

   localparam int unsigned CLK_DIV = 4;
   localparam int unsigned LATENCY = 1 + 8 * CLK_DIV;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req = 1'b0;
   logic       finish = 1'b0;
   logic [7:0] din = '0;
   logic       done;
   logic [7:0] dout;
   logic       spi_sclk;
   logic       spi_miso;
   logic       spi_mosi;
   logic       spi_cs;

   typedef struct {
      logic [7:0]  tx;
      logic [7:0]  rx;
      int unsigned cyc;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        mon_e;
   int unsigned total = 0;
   int unsigned bad = 0;
   int unsigned cyc = 0;
   int unsigned done_cnt = 0;
   int unsigned base = 0;
   bit          loopback = 1'b0;
   bit          cs_low_exp = 1'b0;
   logic [7:0]  slave_byte = '0;
   logic [7:0]  mosi_cap = '0;
   logic [2:0]  bit_idx = '0;
   logic        sclk_q_s = 1'b0;
   logic        sclk_q_m = 1'b0;
   logic        mosi_q_m = 1'b0;
   logic        done_q_m = 1'b0;

   spi_byte_master #(
      .CLK_DIV(CLK_DIV)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .din      (din),
      .finish   (finish),
      .done     (done),
      .dout     (dout),
      .spi_sclk (spi_sclk),
      .spi_miso (spi_miso),
      .spi_mosi (spi_mosi),
      .spi_cs   (spi_cs)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Slave: presents slave_byte MSB first, advancing one bit after each sclk fall.
   assign spi_miso = loopback ? spi_mosi : slave_byte[3'd7 - bit_idx];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int unsigned n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [7:0] b, input bit loop, input logic [7:0] pat);
      exp_t e;
      din        = b;
      loopback   = loop;
      slave_byte = pat;
      e.tx  = b;
      e.rx  = loop ? b : pat;
      e.cyc = cyc;
      sb_q.push_back(e);
      req = 1'b1;
      tick(1);
      req = 1'b0;
      din = 8'($urandom);
   endtask

   task automatic wait_done(input int unsigned target);
      int unsigned n = 0;
      while (done_cnt < target && n < 40 * CLK_DIV) begin
         din = 8'($urandom);
         tick(1);
         n++;
      end
      check("done_within_budget", 32'(done_cnt >= target), 32'd1);
   endtask

   task automatic pulse_finish();
      finish = 1'b1;
      tick(1);
      finish = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cs"},   32'(spi_cs),   32'd1);
      check({tag, "_sclk"}, 32'(spi_sclk), 32'd0);
      check({tag, "_mosi"}, 32'(spi_mosi), 32'd0);
      check({tag, "_done"}, 32'(done),     32'd0);
      check({tag, "_dout"}, 32'(dout),     32'd0);
   endtask

   initial forever begin
      @(negedge clk);
      if (rst) begin
         bit_idx = '0;
      end else begin
         if (spi_sclk && !sclk_q_s) mosi_cap = {mosi_cap[6:0], spi_mosi};
         if (!spi_sclk && sclk_q_s) bit_idx = bit_idx + 3'd1;
      end
      sclk_q_s = spi_sclk;
   end

   initial forever begin
      @(negedge clk);
      if (!rst) begin
         if (spi_cs) check("sclk_idle_while_cs_high", 32'(spi_sclk), 32'd0);
         if (spi_sclk && sclk_q_m) check("mosi_stable_while_sclk_high", 32'(spi_mosi), 32'(mosi_q_m));
         if (cs_low_exp) check("cs_low_in_transaction", 32'(spi_cs), 32'd0);
         if (done) begin
            done_cnt++;
            check("done_one_cycle", 32'(done_q_m), 32'd0);
            check("done_expected", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
               mon_e = sb_q.pop_front();
               check("dout_byte", 32'(dout), 32'(mon_e.rx));
               check("mosi_byte", 32'(mosi_cap), 32'(mon_e.tx));
               check("done_latency", cyc - mon_e.cyc, LATENCY);
            end
         end
      end
      sclk_q_m = spi_sclk;
      mosi_q_m = spi_mosi;
      done_q_m = done;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      check_reset_outputs("reset");

      send(8'hA5, 1'b1, 8'h00);
      cs_low_exp = 1'b1;
      wait_done(1);
      tick(6);
      pulse_finish();
      cs_low_exp = 1'b0;
      check("cs_release_loopback", 32'(spi_cs), 32'd1);

      send(8'($urandom), 1'b0, 8'h3C);
      cs_low_exp = 1'b1;
      wait_done(2);
      pulse_finish();
      cs_low_exp = 1'b0;
      check("cs_release_pattern", 32'(spi_cs), 32'd1);
      tick(5);
      check("dout_held", 32'(dout), 32'h3C);

      pulse_finish();
      tick(3);
      check("finish_in_idle_cs", 32'(spi_cs), 32'd1);
      check("finish_in_idle_no_done", done_cnt, 32'd2);

      base = done_cnt;
      for (int unsigned i = 0; i < 8; i++) begin
         send(8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom));
         cs_low_exp = 1'b1;
         if (i < 7) begin
            repeat (64) begin
               din = 8'($urandom);
               tick(1);
            end
         end
      end
      wait_done(base + 8);
      pulse_finish();
      cs_low_exp = 1'b0;
      check("cs_release_burst", 32'(spi_cs), 32'd1);
      tick(20);
      check("burst_done_count", done_cnt - base, 32'd8);

      base = done_cnt;
      send(8'($urandom), 1'b0, 8'($urandom));
      cs_low_exp = 1'b1;
      tick(10);
      pulse_finish();
      tick(4);
      req = 1'b1;
      tick(1);
      req = 1'b0;
      wait_done(base + 1);
      cs_low_exp = 1'b0;
      check("cs_release_pending_finish", 32'(spi_cs), 32'd1);
      tick(40);
      check("req_in_xfer_ignored", done_cnt - base, 32'd1);
      check("cs_idle_after_pending", 32'(spi_cs), 32'd1);

      send(8'($urandom), 1'b1, 8'h00);
      cs_low_exp = 1'b1;
      wait_done(base + 2);
      tick(2);
      req    = 1'b1;
      finish = 1'b1;
      tick(1);
      req    = 1'b0;
      finish = 1'b0;
      cs_low_exp = 1'b0;
      check("finish_beats_req_cs", 32'(spi_cs), 32'd1);
      tick(45);
      check("finish_beats_req_no_done", done_cnt - base, 32'd2);

      base = done_cnt;
      send(8'($urandom), 1'b0, 8'($urandom));
      cs_low_exp = 1'b1;
      tick(4 * CLK_DIV + 1);
      rst = 1'b1;
      cs_low_exp = 1'b0;
      tick(2);
      rst = 1'b0;
      sb_q.delete();
      check_reset_outputs("midrst");
      tick(40);
      check("midrst_no_done", done_cnt - base, 32'd0);
      send(8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom));
      cs_low_exp = 1'b1;
      wait_done(base + 1);
      pulse_finish();
      cs_low_exp = 1'b0;
      check("cs_release_after_midrst", 32'(spi_cs), 32'd1);

      tick(5);
      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
